// File: rtl/pref_queue.sv
// Prefetch request queue: line-deduplicating circular FIFO.
// Takes up to three candidates per cycle and issues one line-aligned request per handshake.
module pref_queue #(
    parameter int DEPTH           = 8,
    parameter int ADDR_SIZE       = 64,
    parameter int LOG2_BLOCK_SIZE = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_SIZE-1:0]     pref_addr1_i,
    input  logic [ADDR_SIZE-1:0]     pref_addr2_i,
    input  logic [ADDR_SIZE-1:0]     pref_addr3_i,
    input  logic                     pref_valid1_i,
    input  logic                     pref_valid2_i,
    input  logic                     pref_valid3_i,
    output logic [ADDR_SIZE-1:0]     req_addr_o,
    output logic                     req_valid_o,
    input  logic                     req_ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [15:0]              drop_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = ADDR_SIZE - LOG2_BLOCK_SIZE;

    logic [LW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [15:0]      drop_cnt;

    logic [LW-1:0]    cand_line [3];
    logic [2:0]       cand_vld;
    logic [2:0]       uniq;
    logic [CW-1:0]    free;
    logic [CW-1:0]    acc;
    logic [1:0]       drops;
    logic [PW-1:0]    slot;
    logic [DEPTH-1:0] wr_en;
    logic [LW-1:0]    wr_line [DEPTH];
    logic             deq;
    logic [16:0]      dsum;

    assign cand_line[0] = pref_addr1_i[ADDR_SIZE-1:LOG2_BLOCK_SIZE];
    assign cand_line[1] = pref_addr2_i[ADDR_SIZE-1:LOG2_BLOCK_SIZE];
    assign cand_line[2] = pref_addr3_i[ADDR_SIZE-1:LOG2_BLOCK_SIZE];
    assign cand_vld     = {pref_valid3_i, pref_valid2_i, pref_valid1_i};

    assign deq  = (count != '0) && req_ready_i;
    // Space is judged before this cycle's dequeue takes effect.
    assign free = CW'(DEPTH) - count;

    // A candidate survives only if no stored line and no earlier valid candidate matches it.
    always_comb begin
        uniq = '0;
        for (int k = 0; k < 3; k++) begin
            uniq[k] = cand_vld[k];
            for (int i = 0; i < DEPTH; i++) begin
                if (vld[i] && (mem[i] == cand_line[k])) uniq[k] = 1'b0;
            end
            for (int j = 0; j < k; j++) begin
                if (cand_vld[j] && (cand_line[j] == cand_line[k])) uniq[k] = 1'b0;
            end
        end
    end

    // Place survivors into consecutive tail slots in priority order; overflow is dropped.
    always_comb begin
        acc   = '0;
        drops = '0;
        wr_en = '0;
        slot  = '0;
        for (int i = 0; i < DEPTH; i++) wr_line[i] = '0;
        for (int k = 0; k < 3; k++) begin
            if (uniq[k]) begin
                if (acc < free) begin
                    slot          = tail + acc[PW-1:0];
                    wr_en[slot]   = 1'b1;
                    wr_line[slot] = cand_line[k];
                    acc           = acc + CW'(1);
                end else begin
                    drops = drops + 2'd1;
                end
            end
        end
        dsum = {1'b0, drop_cnt} + {15'd0, drops};
    end

    // Pointers, occupancy, entry-valid bits and saturating drop counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            vld      <= '0;
            drop_cnt <= '0;
        end else begin
            count <= count + acc - CW'(deq);
            head  <= head + PW'(deq);
            tail  <= tail + acc[PW-1:0];
            for (int i = 0; i < DEPTH; i++) begin
                if (deq && (head == PW'(i))) vld[i] <= 1'b0;
                else if (wr_en[i])           vld[i] <= 1'b1;
            end
            drop_cnt <= dsum[16] ? 16'hFFFF : dsum[15:0];
        end
    end

    // Line storage; contents are don't-care until the slot is marked valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst && wr_en[i]) mem[i] <= wr_line[i];
        end
    end

    assign req_valid_o = (count != '0);
    assign req_addr_o  = req_valid_o ?
                         {mem[head], {LOG2_BLOCK_SIZE{1'b0}}} : '0;
    assign count_o     = count;
    assign drop_cnt_o  = drop_cnt;

endmodule

// File: tb/tb_pref_queue.sv
// Directed bench for pref_queue.
// Steps drive inputs #1 after a rising edge; checks sample at the same point.
module tb_pref_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] a1, a2, a3;
    logic        v1, v2, v3;
    logic [63:0] req_addr;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  count;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_drain [7];

    always #5 clk = ~clk;

    pref_queue #(
        .DEPTH(8),
        .ADDR_SIZE(64),
        .LOG2_BLOCK_SIZE(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pref_addr1_i(a1),
        .pref_addr2_i(a2),
        .pref_addr3_i(a3),
        .pref_valid1_i(v1),
        .pref_valid2_i(v2),
        .pref_valid3_i(v3),
        .req_addr_o(req_addr),
        .req_valid_o(req_valid),
        .req_ready_i(req_ready),
        .count_o(count),
        .drop_cnt_o(drop_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set3(input logic [63:0] x1, input logic y1,
                        input logic [63:0] x2, input logic y2,
                        input logic [63:0] x3, input logic y3);
        a1 = x1; v1 = y1;
        a2 = x2; v2 = y2;
        a3 = x3; v3 = y3;
    endtask

    task automatic clr;
        set3(64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        req_ready = 1'b0;
        clr();
        tick();
        tick();
        check("rst_valid", {63'd0, req_valid}, 64'd0);
        check("rst_count", {60'd0, count}, 64'd0);
        check("rst_drop", {48'd0, drop_cnt}, 64'd0);
        check("rst_addr", req_addr, 64'd0);
        rst = 1'b1;
        tick();

        // ordering
        set3(64'h1000, 1'b1, 64'h1040, 1'b1, 64'h1080, 1'b1);
        tick();
        clr();
        check("ord_count", {60'd0, count}, 64'd3);
        check("ord_valid", {63'd0, req_valid}, 64'd1);
        check("ord_a0", req_addr, 64'h1000);
        req_ready = 1'b1;
        tick();
        check("ord_a1", req_addr, 64'h1040);
        tick();
        check("ord_a2", req_addr, 64'h1080);
        tick();
        check("ord_empty", {63'd0, req_valid}, 64'd0);
        check("ord_cnt0", {60'd0, count}, 64'd0);
        req_ready = 1'b0;

        // dedup within a cycle, against the queue, and against the retiring head
        set3(64'h2010, 1'b1, 64'h2030, 1'b1, 64'h0, 1'b0);
        tick();
        clr();
        check("dd_count", {60'd0, count}, 64'd1);
        check("dd_addr", req_addr, 64'h2000);
        check("dd_drop", {48'd0, drop_cnt}, 64'd0);
        set3(64'h2008, 1'b1, 64'h0, 1'b0, 64'h0, 1'b0);
        tick();
        clr();
        check("dd_count2", {60'd0, count}, 64'd1);
        check("dd_drop2", {48'd0, drop_cnt}, 64'd0);
        req_ready = 1'b1;
        set3(64'h2020, 1'b1, 64'h0, 1'b0, 64'h0, 1'b0);
        tick();
        clr();
        req_ready = 1'b0;
        check("dd_head_cnt", {60'd0, count}, 64'd0);
        check("dd_head_drop", {48'd0, drop_cnt}, 64'd0);

        // full
        for (int i = 0; i < 8; i++) begin
            set3(64'h3000 + 64'(i) * 64'h40, 1'b1, 64'h0, 1'b0, 64'h0, 1'b0);
            tick();
        end
        clr();
        check("full_count", {60'd0, count}, 64'd8);
        check("full_head", req_addr, 64'h3000);
        set3(64'h4000, 1'b1, 64'h4040, 1'b1, 64'h4080, 1'b1);
        tick();
        clr();
        check("full_count2", {60'd0, count}, 64'd8);
        check("full_drop", {48'd0, drop_cnt}, 64'd3);
        check("full_head2", req_addr, 64'h3000);
        set3(64'h3040, 1'b1, 64'h0, 1'b0, 64'h0, 1'b0);
        tick();
        clr();
        check("full_dup_drop", {48'd0, drop_cnt}, 64'd3);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("sim_pre_cnt", {60'd0, count}, 64'd7);
        check("sim_pre_head", req_addr, 64'h3040);

        // simultaneous dequeue and enqueue at count 7
        req_ready = 1'b1;
        set3(64'h5000, 1'b1, 64'h5040, 1'b1, 64'h5080, 1'b1);
        tick();
        clr();
        req_ready = 1'b0;
        check("sim_count", {60'd0, count}, 64'd7);
        check("sim_drop", {48'd0, drop_cnt}, 64'd5);
        check("sim_head", req_addr, 64'h3080);
        exp_drain[0] = 64'h3080;
        exp_drain[1] = 64'h30c0;
        exp_drain[2] = 64'h3100;
        exp_drain[3] = 64'h3140;
        exp_drain[4] = 64'h3180;
        exp_drain[5] = 64'h31c0;
        exp_drain[6] = 64'h5000;
        req_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("drain_%0d", i), req_addr, exp_drain[i]);
            tick();
        end
        check("drain_empty", {63'd0, req_valid}, 64'd0);

        // wrap: 20 lines streamed through, offsets must be stripped
        for (int i = 0; i < 20; i++) begin
            set3(64'h8000 + 64'(i) * 64'h40 + 64'(i), 1'b1,
                 64'h0, 1'b0, 64'h0, 1'b0);
            tick();
            check($sformatf("wrap_a%0d", i), req_addr,
                  64'h8000 + 64'(i) * 64'h40);
            check($sformatf("wrap_c%0d", i), {60'd0, count}, 64'd1);
        end
        clr();
        tick();
        check("wrap_empty", {63'd0, req_valid}, 64'd0);
        req_ready = 1'b0;

        // reset with occupancy 5 and simultaneous traffic
        for (int i = 0; i < 5; i++) begin
            set3(64'h9000 + 64'(i) * 64'h40, 1'b1, 64'h0, 1'b0, 64'h0, 1'b0);
            tick();
        end
        clr();
        check("r5_count", {60'd0, count}, 64'd5);
        rst = 1'b0;
        req_ready = 1'b1;
        set3(64'hA000, 1'b1, 64'hA040, 1'b1, 64'hA080, 1'b1);
        tick();
        rst = 1'b1;
        clr();
        check("r5_cnt0", {60'd0, count}, 64'd0);
        check("r5_valid", {63'd0, req_valid}, 64'd0);
        check("r5_addr", req_addr, 64'd0);
        check("r5_drop", {48'd0, drop_cnt}, 64'd0);
        tick();
        check("r5_after_v", {63'd0, req_valid}, 64'd0);
        check("r5_after_c", {60'd0, count}, 64'd0);
        req_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
